// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcode encodings, flag bit
// positions and the flag pattern reported for an illegal opcode.
package alu_pkg;

   localparam logic [3:0] OP_PASSA = 4'd0;
   localparam logic [3:0] OP_PASSB = 4'd1;
   localparam logic [3:0] OP_ADD   = 4'd2;
   localparam logic [3:0] OP_SUB   = 4'd3;
   localparam logic [3:0] OP_AND   = 4'd4;
   localparam logic [3:0] OP_OR    = 4'd5;
   localparam logic [3:0] OP_XOR   = 4'd6;
   localparam logic [3:0] OP_NOTA  = 4'd7;
   localparam logic [3:0] OP_SHL   = 4'd8;
   localparam logic [3:0] OP_SHR   = 4'd9;
   localparam logic [3:0] OP_SRA   = 4'd10;

   // flags vector is {N,Z,C,V}
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] ALU_ERR_FLAGS = 4'b0100;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: decodes the opcode and produces the result,
// the {N,Z,C,V} flags and an illegal-opcode indication.
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic [OPW-1:0]   op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic [3:0]       flags_o,
   output logic             err_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] sh_s;
   logic [WIDTH:0] add_s;
   logic [WIDTH:0] sub_s;
   logic [WIDTH:0] shl_s;
   logic [WIDTH:0] shr_s;
   logic [WIDTH:0] sra_s;
   logic [WIDTH-1:0] res_s;
   logic carry_s;
   logic ovf_s;
   logic err_s;

   assign sh_s  = b_i[SHW-1:0];
   assign add_s = {1'b0, a_i} + {1'b0, b_i};
   assign sub_s = {1'b0, a_i} - {1'b0, b_i};
   // One spare bit beside the operand catches the last bit shifted out.
   assign shl_s = {1'b0, a_i} << sh_s;
   assign shr_s = {a_i, 1'b0} >> sh_s;
   assign sra_s = $signed({a_i, 1'b0}) >>> sh_s;

   // Opcode decode into result, carry, overflow and error
   always_comb begin
      res_s   = {WIDTH{1'b0}};
      carry_s = 1'b0;
      ovf_s   = 1'b0;
      err_s   = 1'b0;
      case (op_i)
         OP_PASSA: res_s = a_i;
         OP_PASSB: res_s = b_i;
         OP_ADD: begin
            res_s   = add_s[WIDTH-1:0];
            carry_s = add_s[WIDTH];
            ovf_s   = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (add_s[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_SUB: begin
            res_s   = sub_s[WIDTH-1:0];
            carry_s = ~sub_s[WIDTH];
            ovf_s   = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (sub_s[WIDTH-1] != a_i[WIDTH-1]);
         end
         OP_AND:  res_s = a_i & b_i;
         OP_OR:   res_s = a_i | b_i;
         OP_XOR:  res_s = a_i ^ b_i;
         OP_NOTA: res_s = ~a_i;
         OP_SHL: begin
            res_s   = shl_s[WIDTH-1:0];
            carry_s = shl_s[WIDTH];
         end
         OP_SHR: begin
            res_s   = shr_s[WIDTH:1];
            carry_s = shr_s[0];
         end
         OP_SRA: begin
            res_s   = sra_s[WIDTH:1];
            carry_s = sra_s[0];
         end
         default: err_s = 1'b1;
      endcase
   end

   // Flag assembly; illegal opcodes report a fixed pattern
   always_comb begin
      result_o = res_s;
      err_o    = err_s;
      flags_o  = 4'b0000;
      if (err_s) begin
         flags_o = ALU_ERR_FLAGS;
      end else begin
         flags_o[FLAG_N] = res_s[WIDTH-1];
         flags_o[FLAG_Z] = (res_s == {WIDTH{1'b0}});
         flags_o[FLAG_C] = carry_s;
         flags_o[FLAG_V] = ovf_s;
      end
   end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: S1 holds the operands, S2 holds the
// registered result; both stages can advance in the same cycle.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int OPW   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OPW-1:0]   op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             a_zero,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags,
   output logic             err
);

   logic             s1_valid_q, s1_valid_d;
   logic [OPW-1:0]   s1_op_q, s1_op_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [3:0]       flags_q, flags_d;
   logic             err_q, err_d;

   logic [WIDTH-1:0] core_result_s;
   logic [3:0]       core_flags_s;
   logic             core_err_s;
   logic             s1_load_s;
   logic             s2_load_s;

   alu_core #(
      .WIDTH (WIDTH),
      .OPW   (OPW)
   ) u_core (
      .op_i     (s1_op_q),
      .a_i      (s1_a_q),
      .b_i      (s1_b_q),
      .result_o (core_result_s),
      .flags_o  (core_flags_s),
      .err_o    (core_err_s)
   );

   assign a_zero    = (a == {WIDTH{1'b0}});
   assign in_ready  = !s1_valid_q || !out_valid_q || out_ready;
   assign s1_load_s = in_valid && in_ready;
   assign s2_load_s = s1_valid_q && (!out_valid_q || out_ready);

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign flags     = flags_q;
   assign err       = err_q;

   // Next-state for both stages; S1 empties only when S2 takes its contents
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_a_d      = s1_a_q;
      s1_b_d      = s1_b_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      flags_d     = flags_q;
      err_d       = err_q;
      if (s1_load_s) begin
         s1_valid_d = 1'b1;
         s1_op_d    = op;
         s1_a_d     = a;
         s1_b_d     = b;
      end else if (s2_load_s) begin
         s1_valid_d = 1'b0;
      end else begin
         s1_valid_d = s1_valid_q;
      end
      if (s2_load_s) begin
         out_valid_d = 1'b1;
         result_d    = core_result_s;
         flags_d     = core_flags_s;
         err_d       = core_err_s;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end else begin
         out_valid_d = out_valid_q;
      end
   end

   // Pipeline registers with asynchronous clear of all in-flight state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_op_q     <= {OPW{1'b0}};
         s1_a_q      <= {WIDTH{1'b0}};
         s1_b_q      <= {WIDTH{1'b0}};
         out_valid_q <= 1'b0;
         result_q    <= {WIDTH{1'b0}};
         flags_q     <= 4'b0000;
         err_q       <= 1'b0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_a_q      <= s1_a_d;
         s1_b_q      <= s1_b_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         flags_q     <= flags_d;
         err_q       <= err_d;
      end
   end

endmodule
